// File: rtl/press_classifier_pkg.sv
// Shared types and helpers for the press_classifier gesture decoder.
package press_classifier_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRESS1,
    WAIT_GAP,
    PRESS2,
    LONG_HOLD
  } state_e;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/press_timer.sv
// Saturating sample counter shared by all classifier states, with an equality terminal compare.
module press_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic         at_term
);

  logic [W-1:0] count_q, count_d;

  // clr with en loads 1 so the sample that causes a state change is already counted
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = en ? W'(1) : '0;
    end else if (en && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign at_term = (count_q == term);

endmodule

// File: rtl/press_classifier.sv
// Debounced-button gesture classifier: single click, double click and long press pulses.
// Define PRESS_REPEAT_EN to re-pulse long_press every REPEAT_CYCLES while the button stays held.
module press_classifier
  import press_classifier_pkg::*;
#(
  parameter int unsigned LONG_CYCLES   = 50_000_000,
  parameter int unsigned GAP_CYCLES    = 15_000_000,
  parameter int unsigned REPEAT_CYCLES = 10_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic button_level,
  output logic single_click,
  output logic double_click,
  output logic long_press,
  output logic held
);

`ifdef PRESS_REPEAT_EN
  localparam int unsigned MaxCycles = max3(LONG_CYCLES, GAP_CYCLES, REPEAT_CYCLES);
`else
  localparam int unsigned MaxCycles = max3(LONG_CYCLES, GAP_CYCLES, 2);
`endif
  localparam int unsigned CntW = $clog2(MaxCycles);

  // Compare against N-1: the deciding sample is the one arriving while the count reads N-1
  localparam logic [CntW-1:0] LongTerm = CntW'(LONG_CYCLES - 1);
  localparam logic [CntW-1:0] GapTerm  = CntW'(GAP_CYCLES - 1);
`ifdef PRESS_REPEAT_EN
  localparam logic [CntW-1:0] RepTerm  = CntW'(REPEAT_CYCLES - 1);
`endif

  state_e          state_q, state_d;
  logic            armed_q, armed_d;
  logic            held_q, held_d;
  logic            single_q, single_d;
  logic            double_q, double_d;
  logic            long_q, long_d;
  logic            tmr_clr, tmr_en, tmr_at_term;
  logic [CntW-1:0] tmr_term;

  press_timer #(
    .W(CntW)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .term    (tmr_term),
    .at_term (tmr_at_term)
  );

  always_comb begin
    state_d  = state_q;
    armed_d  = armed_q | ~button_level;
    held_d   = button_level & armed_q;
    single_d = 1'b0;
    double_d = 1'b0;
    long_d   = 1'b0;
    tmr_clr  = 1'b0;
    tmr_en   = 1'b0;
    tmr_term = LongTerm;

    case (state_q)
      IDLE: begin
        if (armed_q && button_level) begin
          state_d = PRESS1;
          tmr_clr = 1'b1;
          tmr_en  = 1'b1;
        end
      end
      PRESS1: begin
        tmr_term = LongTerm;
        if (!button_level) begin
          state_d = WAIT_GAP;
          tmr_clr = 1'b1;
          tmr_en  = 1'b1;
        end else if (tmr_at_term) begin
          long_d  = 1'b1;
          state_d = LONG_HOLD;
          tmr_clr = 1'b1;
        end else begin
          tmr_en = 1'b1;
        end
      end
      WAIT_GAP: begin
        tmr_term = GapTerm;
        // A rising level takes priority over an expiring gap
        if (button_level) begin
          state_d = PRESS2;
          tmr_clr = 1'b1;
        end else if (tmr_at_term) begin
          single_d = 1'b1;
          state_d  = IDLE;
          tmr_clr  = 1'b1;
        end else begin
          tmr_en = 1'b1;
        end
      end
      PRESS2: begin
        if (!button_level) begin
          double_d = 1'b1;
          state_d  = IDLE;
          tmr_clr  = 1'b1;
        end
      end
      LONG_HOLD: begin
        if (!button_level) begin
          state_d = IDLE;
          tmr_clr = 1'b1;
        end
`ifdef PRESS_REPEAT_EN
        else begin
          tmr_term = RepTerm;
          if (tmr_at_term) begin
            long_d  = 1'b1;
            tmr_clr = 1'b1;
          end else begin
            tmr_en = 1'b1;
          end
        end
`endif
      end
      default: begin
        state_d = IDLE;
        tmr_clr = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      armed_q  <= 1'b0;
      held_q   <= 1'b0;
      single_q <= 1'b0;
      double_q <= 1'b0;
      long_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      armed_q  <= armed_d;
      held_q   <= held_d;
      single_q <= single_d;
      double_q <= double_d;
      long_q   <= long_d;
    end
  end

  assign single_click = single_q;
  assign double_click = double_q;
  assign long_press   = long_q;
  assign held         = held_q;

endmodule

// File: tb/tb_press_classifier.sv
// Self-checking bench for press_classifier: run-length reference model plus directed latency pins.
module tb_press_classifier;

  localparam int unsigned L = 20;
  localparam int unsigned G = 10;
  localparam int unsigned R = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic button_level = 1'b0;
  logic single_click, double_click, long_press, held;

  press_classifier #(
    .LONG_CYCLES   (L),
    .GAP_CYCLES    (G),
    .REPEAT_CYCLES (R)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .button_level (button_level),
    .single_click (single_click),
    .double_click (double_click),
    .long_press   (long_press),
    .held         (held)
  );

  always #10 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: gesture described by press count, current level and run length
  int smp = 0;
  bit m_armed = 0;
  int presses = 0;
  bit m_down = 0;
  bit m_long = 0;
  int run = 0;
  bit exp_single = 0, exp_double = 0, exp_long = 0, exp_held = 0;

  task automatic model_step(input bit b);
    if (presses == 0) begin
      if (b) begin
        presses = 1;
        m_down  = 1;
        run     = 1;
      end
    end else if (m_long) begin
      if (b) begin
        run++;
`ifdef PRESS_REPEAT_EN
        if (((run - int'(L)) % int'(R)) == 0) exp_long = 1;
`endif
      end else begin
        presses = 0;
        m_long  = 0;
      end
    end else if (presses == 1 && m_down) begin
      if (b) begin
        run++;
        if (run == int'(L)) begin
          exp_long = 1;
          m_long   = 1;
        end
      end else begin
        m_down = 0;
        run    = 1;
      end
    end else if (presses == 1) begin
      if (b) begin
        presses = 2;
        m_down  = 1;
      end else begin
        run++;
        if (run == int'(G)) begin
          exp_single = 1;
          presses    = 0;
        end
      end
    end else begin
      if (!b) begin
        exp_double = 1;
        presses    = 0;
      end
    end
  endtask

  always @(posedge clk) begin
    smp++;
    exp_single = 0;
    exp_double = 0;
    exp_long   = 0;
    if (reset) begin
      m_armed  = 0;
      presses  = 0;
      m_long   = 0;
      run      = 0;
      exp_held = 0;
    end else begin
      exp_held = button_level && m_armed;
      if (!m_armed) begin
        if (!button_level) m_armed = 1;
      end else begin
        model_step(button_level);
      end
    end
  end

  task automatic cmp(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s at sample %0d: got %0d, expected %0d", name, smp, act, exp);
    end
  endtask

  // Observed pulse history, used by the directed latency checks
  int n_single = 0, n_double = 0, n_long = 0;
  int last_single = -1, last_double = -1, last_long = -1, first_long = -1;

  always @(negedge clk) begin
    cmp("single_click", int'(single_click), int'(exp_single));
    cmp("double_click", int'(double_click), int'(exp_double));
    cmp("long_press", int'(long_press), int'(exp_long));
    cmp("held", int'(held), int'(exp_held));
    if (single_click) begin
      n_single++;
      last_single = smp;
    end
    if (double_click) begin
      n_double++;
      last_double = smp;
    end
    if (long_press) begin
      n_long++;
      if (first_long < 0 || last_long < smp - int'(L)) first_long = smp;
      last_long = smp;
    end
  end

  // Each call starts just after a negedge; every level is sampled by the next posedge
  task automatic drive(input bit lvl, input int n);
    repeat (n) begin
      button_level = lvl;
      @(negedge clk);
    end
  endtask

  int s0, b_s, b_d, b_l;

  task automatic mark();
    s0  = smp;
    b_s = n_single;
    b_d = n_double;
    b_l = n_long;
  endtask

  initial begin
    reset = 1'b1;
    button_level = 1'b0;
    repeat (3) @(negedge clk);
    cmp("reset_outputs", int'({single_click, double_click, long_press, held}), 0);
    reset = 1'b0;
    drive(0, 3);

    // Single click: 5 high, release; pulse on the 10th low sample
    mark();
    drive(1, 5);
    drive(0, 14);
    cmp("single_latency", last_single - s0, 15);
    cmp("single_count", n_single - b_s, 1);
    cmp("single_no_other", (n_double - b_d) + (n_long - b_l), 0);

    // Double click: high 5, low 4, high 3, low
    mark();
    drive(1, 5);
    drive(0, 4);
    drive(1, 3);
    drive(0, 14);
    cmp("double_latency", last_double - s0, 13);
    cmp("double_no_single", n_single - b_s, 0);

    // Long press: 40 high samples
    mark();
    first_long = -1;
    drive(1, 40);
    drive(0, 12);
    cmp("long_latency", first_long - s0, 20);
`ifdef PRESS_REPEAT_EN
    cmp("long_count", n_long - b_l, 5);
    cmp("long_last", last_long - s0, 40);
`else
    cmp("long_count", n_long - b_l, 1);
`endif
    cmp("long_no_click", (n_single - b_s) + (n_double - b_d), 0);

    // One sample short of a long press
    mark();
    drive(1, 19);
    drive(0, 14);
    cmp("boundary_no_long", n_long - b_l, 0);
    cmp("boundary_single", last_single - s0, 29);

    // Second press lands in the 10th gap slot
    mark();
    drive(1, 5);
    drive(0, 9);
    drive(1, 2);
    drive(0, 14);
    cmp("gap_double", last_double - s0, 17);
    cmp("gap_no_single", n_single - b_s, 0);

    // Reset while waiting in the gap aborts silently
    mark();
    drive(1, 5);
    drive(0, 3);
    reset = 1'b1;
    drive(0, 1);
    reset = 1'b0;
    drive(0, 15);
    cmp("reset_mid_no_events", (n_single - b_s) + (n_double - b_d) + (n_long - b_l), 0);

    // Held through reset release: ignored until a low sample arms the block
    mark();
    reset = 1'b1;
    drive(1, 2);
    reset = 1'b0;
    drive(1, 30);
    cmp("held_unarmed", int'(held), 0);
    cmp("held_through_no_events", (n_single - b_s) + (n_double - b_d) + (n_long - b_l), 0);
    drive(0, 3);
    mark();
    drive(1, 5);
    drive(0, 14);
    cmp("rearm_single", last_single - s0, 15);

    // Randomized runs, biased around the thresholds, with occasional resets
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 30) == 0) begin
        reset = 1'b1;
        drive(button_level, int'($urandom_range(1, 2)));
        reset = 1'b0;
      end else if ($urandom_range(0, 6) == 0) begin
        drive(~button_level, int'($urandom_range(18, 45)));
      end else begin
        drive(~button_level, int'($urandom_range(1, 12)));
      end
    end
    drive(0, 15);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
